// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the fetch / load-store memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_ADDR_WIDTH  = 32;
  localparam int unsigned DEF_MEM_LATENCY = 2;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between the fetch and
// load/store requesters, one transaction at a time, alternating on conflict.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ready,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_ready,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_t       state, state_next;
  owner_t           owner, last_grant, grant_owner;
  logic             grant;
  logic             txn_we;
  logic [CNT_W-1:0] cnt;
  logic             rsp_valid;

  // The response beat is the last WAIT cycle; everything keyed on it lines up
  // with the DONE state that follows.
  assign rsp_valid = (state == WAIT) && (cnt == '0);

  // Next-state and grant selection; conflicts go to the side not served last.
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    grant_owner = OWN_IF;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant      = 1'b1;
          state_next = ISSUE;
          if (if_req && d_req)
            grant_owner = (last_grant == OWN_IF) ? OWN_D : OWN_IF;
          else if (d_req)
            grant_owner = OWN_D;
          else
            grant_owner = OWN_IF;
        end
      end
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Ownership, alternation history and latency countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      txn_we     <= 1'b0;
      cnt        <= '0;
    end else begin
      if (grant) begin
        owner      <= grant_owner;
        last_grant <= grant_owner;
        txn_we     <= (grant_owner == OWN_D) ? d_we : 1'b0;
      end
      if (state == ISSUE)
        cnt <= CNT_W'(MEM_LATENCY - 1);
      else if ((state == WAIT) && (cnt != '0))
        cnt <= cnt - CNT_W'(1);
    end
  end

  // Memory command: loaded on the grant edge so it is valid exactly in ISSUE,
  // and zero in every other cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (grant && (grant_owner == OWN_D)) begin
      mem_req   <= 1'b1;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_be    <= d_be;
    end else if (grant) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      mem_be    <= '1;
    end else begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end
  end

  // Response capture, ready pulses and the stall flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      busy     <= 1'b0;
    end else begin
      if_ready <= rsp_valid && (owner == OWN_IF);
      d_ready  <= rsp_valid && (owner == OWN_D);
      if (rsp_valid && (owner == OWN_IF))
        if_rdata <= mem_rdata;
      if (rsp_valid && (owner == OWN_D) && !txn_we)
        d_rdata <= mem_rdata;
      busy <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default latency plus a latency-1 copy).
module tb_mem_arbiter;

  localparam logic [31:0] PAT  = 32'h5A5A_0000;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst;

  logic        if_req, if_ready, d_req, d_we, d_ready;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic        mem_req, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        if_req1, if_ready1, d_req1, d_we1, d_ready1;
  logic [31:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1;
  logic [3:0]  d_be1, mem_be1;
  logic        mem_req1, mem_we1, busy1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_ready(if_ready1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1), .d_be(d_be1),
    .d_ready(d_ready1), .d_rdata(d_rdata1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_be(mem_be1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  // Latency-2 memory responder: data for a strobe seen in cycle c appears in cycle c+2.
  int          cyc = 0;
  int          pend_due = -1;
  logic [31:0] pend_data = '0;
  logic        use_pattern = 1'b0;
  logic [31:0] resp_data = '0;

  always @(negedge clk) begin
    if (rst) pend_due = -1;
    else if (mem_req) begin
      pend_data = use_pattern ? (mem_addr ^ PAT) : resp_data;
      pend_due  = cyc + 2;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    mem_rdata = (cyc == pend_due) ? pend_data : JUNK;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] mem_rdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  // One isolated transaction, starting at a cycle boundary with the arbiter idle.
  task automatic run_txn(input vec_t v);
    use_pattern = 1'b0;
    resp_data   = v.mem_rdata;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clk);
    check1("txn_idle_busy", busy, 1'b0);
    next_cycle;
    @(negedge clk);
    check1("txn_mem_req", mem_req, 1'b1);
    check1("txn_mem_we", mem_we, v.exp_we);
    check32("txn_mem_addr", mem_addr, v.addr);
    check32("txn_mem_be", {28'b0, mem_be}, {28'b0, v.exp_be});
    if (v.we) check32("txn_mem_wdata", mem_wdata, v.wdata);
    check1("txn_busy_issue", busy, 1'b1);
    next_cycle;
    @(negedge clk);
    check1("txn_mem_req_off", mem_req, 1'b0);
    check32("txn_mem_addr_off", mem_addr, 32'h0);
    check1("txn_busy_wait", busy, 1'b1);
    next_cycle;
    @(negedge clk);
    check1("txn_if_ready_early", if_ready, 1'b0);
    check1("txn_d_ready_early", d_ready, 1'b0);
    next_cycle;
    @(negedge clk);
    check1("txn_if_ready", if_ready, !v.is_d);
    check1("txn_d_ready", d_ready, v.is_d);
    check32("txn_if_rdata", if_rdata, v.exp_if_rdata);
    check32("txn_d_rdata", d_rdata, v.exp_d_rdata);
    check1("txn_busy_done", busy, 1'b1);
    next_cycle;
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    @(negedge clk);
    check1("txn_if_ready_pulse", if_ready, 1'b0);
    check1("txn_d_ready_pulse", d_ready, 1'b0);
    check1("txn_busy_idle", busy, 1'b0);
    next_cycle;
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_d, exp_if, exp_busy;

    vecs[0] = '{0, 0, 32'h0000_0010, 32'h0, 4'h0, 32'h0050_0093, 0, 4'hF, 32'h0050_0093, 32'h0};
    vecs[1] = '{1, 0, 32'h0000_0200, 32'h0, 4'b0101, 32'hCAFE_F00D, 0, 4'b0101, 32'h0050_0093, 32'hCAFE_F00D};
    vecs[2] = '{1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 32'h1111_2222, 1, 4'b0011, 32'h0050_0093, 32'hCAFE_F00D};
    vecs[3] = '{0, 0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'hFFFF_FFFF, 0, 4'hF, 32'hFFFF_FFFF, 32'hCAFE_F00D};
    vecs[4] = '{1, 0, 32'h0000_0004, 32'h0, 4'hF, 32'h0000_0000, 0, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[5] = '{1, 1, 32'h0000_0008, 32'h0, 4'b1000, 32'hABCD_ABCD, 1, 4'b1000, 32'hFFFF_FFFF, 32'h0};

    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    if_req1 = 0; if_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0; d_be1 = 0;
    mem_rdata1 = 32'hBAD1_BAD1;

    // Reset values.
    repeat (2) @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_if_ready", if_ready, 1'b0);
    check1("rst_d_ready", d_ready, 1'b0);
    check32("rst_if_rdata", if_rdata, 32'h0);
    check32("rst_d_rdata", d_rdata, 32'h0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("post_rst_busy", busy, 1'b0);
    next_cycle;

    // Isolated transactions.
    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Continuous conflict from reset: D, IF, D, IF with readies every 5 cycles.
    do_reset;
    use_pattern = 1'b1;
    for (int k = 0; k < 22; k++) begin
      if (k == 0) begin
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
      end
      if (k == 20) begin if_req = 1'b0; d_req = 1'b0; end
      exp_d    = (k == 4) || (k == 14);
      exp_if   = (k == 9) || (k == 19);
      exp_busy = (k >= 1) && (k <= 19) && (k % 5 != 0);
      @(negedge clk);
      check1("alt_d_ready", d_ready, exp_d);
      check1("alt_if_ready", if_ready, exp_if);
      check1("alt_busy", busy, exp_busy);
      if (k == 1 || k == 11) check32("alt_mem_addr_d", mem_addr, d_addr);
      if (k == 6 || k == 16) check32("alt_mem_addr_if", mem_addr, if_addr);
      if (exp_d)  check32("alt_d_rdata", d_rdata, d_addr ^ PAT);
      if (exp_if) check32("alt_if_rdata", if_rdata, if_addr ^ PAT);
      next_cycle;
      if (exp_d)  d_addr  = d_addr + 32'd4;
      if (exp_if) if_addr = if_addr + 32'd4;
    end

    // Reset during WAIT abandons the fetch; a re-presented fetch then completes.
    if_req = 1'b1; if_addr = 32'h80;
    next_cycle;
    next_cycle;
    @(negedge clk);
    check1("midrst_busy_before", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_mem_req", mem_req, 1'b0);
    check1("midrst_if_ready", if_ready, 1'b0);
    check1("midrst_d_ready", d_ready, 1'b0);
    check32("midrst_if_rdata", if_rdata, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check1("midrst_no_ready", if_ready, 1'b0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) if_req = 1'b0;
      @(negedge clk);
      check1("midrst_refetch_ready", if_ready, k == 4);
      if (k == 4) check32("midrst_refetch_rdata", if_rdata, 32'h80 ^ PAT);
      next_cycle;
    end

    // Latency-1 instance: single load, ready at t+3 with data from t+2.
    d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h40; d_be1 = 4'hF;
    @(negedge clk);
    check1("lat1_idle", busy1, 1'b0);
    next_cycle;
    @(negedge clk);
    check1("lat1_mem_req", mem_req1, 1'b1);
    check32("lat1_mem_addr", mem_addr1, 32'h40);
    next_cycle;
    mem_rdata1 = 32'h1234_5678;
    @(negedge clk);
    check1("lat1_ready_early", d_ready1, 1'b0);
    next_cycle;
    mem_rdata1 = 32'hBAD1_BAD1;
    @(negedge clk);
    check1("lat1_ready", d_ready1, 1'b1);
    check32("lat1_rdata", d_rdata1, 32'h1234_5678);
    next_cycle;
    d_req1 = 1'b0;
    @(negedge clk);
    check1("lat1_ready_pulse", d_ready1, 1'b0);
    check1("lat1_busy_idle", busy1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
